// File: rtl/mux_pipe_if.sv
// mux_pipe handshake bundle: input side (data/sel/valid/ready)
// and output side (data/valid/ready).
interface mux_pipe_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
);
  localparam int N = 1 << SEL_W;

  logic [N*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]    in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data,
    output in_sel,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/mux_pipe.sv
// Pipelined N:1 binary mux tree, STAGE_LVLS levels per register stage.
// Optional MUX_PIPE_PARITY_EN adds out_parity = ^out_data.
module mux_pipe #(
  parameter int DATA_W     = 8,
  parameter int SEL_W      = 4,
  parameter int STAGE_LVLS = 2
) (
  input logic       clk,
  input logic       rst,
  mux_pipe_if.slave bus
`ifdef MUX_PIPE_PARITY_EN
  ,
  output logic      out_parity
`endif
);
  localparam int L = (SEL_W + STAGE_LVLS - 1) / STAGE_LVLS;

  logic en;

  assign en = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en | rst;

  for (genvar s = 0; s < L; s++) begin : stg
    localparam int LO = s * STAGE_LVLS;
    localparam int HI = (LO + STAGE_LVLS > SEL_W) ?
                        SEL_W : LO + STAGE_LVLS;
    localparam int NL = HI - LO;
    localparam int SI = SEL_W - LO;
    localparam int SO = SEL_W - HI;
    localparam int WI = 1 << SI;
    localparam int WO = 1 << SO;

    logic [WI*DATA_W-1:0] src;
    logic [SI-1:0]        ssel;
    logic                 sval;
    logic [WO*DATA_W-1:0] mux;
    logic [WO*DATA_W-1:0] d;
    logic                 v;

    // In-place halving: word i reads words 2i/2i+1, never below i.
    function automatic logic [WO*DATA_W-1:0] reduce(
      input logic [WI*DATA_W-1:0] x,
      input logic [NL-1:0]        sl
    );
      logic [WI*DATA_W-1:0] r;
      r = x;
      for (int j = 0; j < NL; j++) begin
        for (int i = 0; i < (WI >> (j + 1)); i++) begin
          r[i*DATA_W +: DATA_W] = sl[j] ?
            r[(2*i+1)*DATA_W +: DATA_W] :
            r[(2*i)*DATA_W +: DATA_W];
        end
      end
      return r[WO*DATA_W-1:0];
    endfunction

    if (s == 0) begin : g_in
      assign src  = bus.in_data;
      assign ssel = bus.in_sel;
      assign sval = bus.in_valid;
    end else begin : g_chain
      assign src  = stg[s-1].d;
      assign ssel = stg[s-1].g_mid.sr;
      assign sval = stg[s-1].v;
    end

    assign mux = reduce(src, ssel[NL-1:0]);

    if (s < L - 1) begin : g_mid
      logic [SO-1:0] sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          v <= 1'b0;
        end else if (en) begin
          v  <= sval;
          d  <= mux;
          sr <= ssel[SI-1:NL];
        end
      end
    end else begin : g_out
      // Output word is forced to zero on bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          v <= 1'b0;
          d <= '0;
        end else if (en) begin
          v <= sval;
          d <= sval ? mux : '0;
        end
      end
    end
  end

  assign bus.out_data  = stg[L-1].d;
  assign bus.out_valid = stg[L-1].v;

`ifdef MUX_PIPE_PARITY_EN
  assign out_parity = ^bus.out_data;
`endif
endmodule

// File: tb/tb_mux_pipe.sv
// Directed + scoreboard bench for mux_pipe: default (L=2)
// plus corner configs SEL_W=1/LVLS=1 and SEL_W=5/LVLS=2.
module tb_mux_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux_pipe_if #(.DATA_W(8), .SEL_W(4)) b0 ();
  mux_pipe_if #(.DATA_W(8), .SEL_W(1)) b1 ();
  mux_pipe_if #(.DATA_W(8), .SEL_W(5)) b2 ();

`ifdef MUX_PIPE_PARITY_EN
  logic p0, p1, p2;
`endif

  mux_pipe #(.DATA_W(8), .SEL_W(4), .STAGE_LVLS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b0)
`ifdef MUX_PIPE_PARITY_EN
    , .out_parity(p0)
`endif
  );

  mux_pipe #(.DATA_W(8), .SEL_W(1), .STAGE_LVLS(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
`ifdef MUX_PIPE_PARITY_EN
    , .out_parity(p1)
`endif
  );

  mux_pipe #(.DATA_W(8), .SEL_W(5), .STAGE_LVLS(2)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(b2)
`ifdef MUX_PIPE_PARITY_EN
    , .out_parity(p2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] e;
  logic       ev;

  initial begin
    rst = 1'b1;
    b0.in_valid = 1'b0; b0.in_sel = '0; b0.in_data = '0;
    b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_sel = '0; b1.in_data = '0;
    b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_sel = '0; b2.in_data = '0;
    b2.out_ready = 1'b1;

    // reset state
    tick;
    tick;
    chk("rst_ov", 32'(b0.out_valid), 32'h0);
    chk("rst_od", 32'(b0.out_data), 32'h0);
    chk("rst_ir", 32'(b0.in_ready), 32'h1);
    rst = 1'b0;
    #1;
    chk("idle_ir", 32'(b0.in_ready), 32'h1);

    // back-to-back sweep
    for (int k = 0; k < 16; k++)
      b0.in_data[k*8 +: 8] = 8'(8'h10 + k);
    b0.in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b0.in_sel = 4'(k);
      tick;
      if (k > 0) begin
        e = 8'(8'h10 + k - 1);
        chk("sweep", {b0.out_valid, b0.out_data}, {23'h0, 1'b1, e});
      end
    end
    b0.in_valid = 1'b0;
    tick;
    chk("sweep_last", {b0.out_valid, b0.out_data}, 32'h11F);
    tick;
    chk("sweep_drain", {b0.out_valid, b0.out_data}, 32'h000);

    // stall with two results in flight
    b0.in_valid = 1'b1;
    b0.in_sel = 4'd5;
    tick;
    b0.in_sel = 4'd9;
    tick;
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b0;
    #1;
    chk("stall_ir0", 32'(b0.in_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("stall_hold", {b0.out_valid, b0.out_data}, 32'h115);
      chk("stall_ir", 32'(b0.in_ready), 32'h0);
    end
    b0.out_ready = 1'b1;
    #1;
    chk("release_ir", 32'(b0.in_ready), 32'h1);
    tick;
    chk("release_2nd", {b0.out_valid, b0.out_data}, 32'h119);
    tick;
    chk("release_empty", {b0.out_valid, b0.out_data}, 32'h000);

    // alternating bubbles
    b0.in_sel = 4'd3;
    for (int i = 0; i < 8; i++) begin
      b0.in_valid = (i % 2) == 0;
      tick;
      ev = (i >= 1) && (((i - 1) % 2) == 0);
      chk("bubble", {b0.out_valid, b0.out_data},
          ev ? 32'h113 : 32'h000);
    end
    b0.in_valid = 1'b0;
    tick;

    // reset with two transfers in flight
    b0.in_valid = 1'b1;
    b0.in_sel = 4'd1;
    tick;
    b0.in_sel = 4'd2;
    tick;
    chk("pre_rst", {b0.out_valid, b0.out_data}, 32'h111);
    rst = 1'b1;
    b0.out_ready = 1'b0;
    b0.in_sel = 4'd7;
    #1;
    chk("rst_ir_stall", 32'(b0.in_ready), 32'h1);
    tick;
    rst = 1'b0;
    b0.out_ready = 1'b1;
    chk("post_rst", {b0.out_valid, b0.out_data}, 32'h000);
    b0.in_sel = 4'd0;
    tick;
    b0.in_valid = 1'b0;
    chk("post_rst_lat", {b0.out_valid, b0.out_data}, 32'h000);
    tick;
    chk("post_rst_sel0", {b0.out_valid, b0.out_data}, 32'h110);
    tick;
    chk("post_rst_drain", {b0.out_valid, b0.out_data}, 32'h000);

`ifdef MUX_PIPE_PARITY_EN
    b0.in_data[2*8 +: 8] = 8'hB3;
    b0.in_data[6*8 +: 8] = 8'h33;
    b0.in_valid = 1'b1;
    b0.in_sel = 4'd2;
    tick;
    b0.in_sel = 4'd6;
    tick;
    b0.in_valid = 1'b0;
    chk("par_b3_data", 32'(b0.out_data), 32'hB3);
    chk("par_b3", 32'(p0), 32'h1);
    tick;
    chk("par_33_data", 32'(b0.out_data), 32'h33);
    chk("par_33", 32'(p0), 32'h0);
    tick;
    chk("par_idle", 32'(p0), 32'h0);
`endif

    // random valid/ready against reference queues, all configs
    for (int c = 0; c < 306; c++) begin
      if (c < 300) begin
        b0.in_valid = 1'($urandom);
        b1.in_valid = 1'($urandom);
        b2.in_valid = 1'($urandom);
        b0.out_ready = ($urandom % 4) != 0;
        b1.out_ready = ($urandom % 3) != 0;
        b2.out_ready = ($urandom % 4) != 0;
      end else begin
        b0.in_valid = 1'b0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.out_ready = 1'b1;
      end
      b0.in_sel = 4'($urandom);
      b1.in_sel = 1'($urandom);
      b2.in_sel = 5'($urandom);
      for (int w = 0; w < 4; w++) b0.in_data[w*32 +: 32] = $urandom;
      b1.in_data = 16'($urandom);
      for (int w = 0; w < 8; w++) b2.in_data[w*32 +: 32] = $urandom;
      #1;
      if (b0.in_valid && b0.in_ready)
        q0.push_back(b0.in_data[b0.in_sel*8 +: 8]);
      if (b1.in_valid && b1.in_ready)
        q1.push_back(b1.in_data[b1.in_sel*8 +: 8]);
      if (b2.in_valid && b2.in_ready)
        q2.push_back(b2.in_data[b2.in_sel*8 +: 8]);
      if (!b0.out_valid) chk("r0_zero", 32'(b0.out_data), 32'h0);
      else if (b0.out_ready) begin
        e = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
        chk("r0_data", 32'(b0.out_data), 32'(e));
      end
      if (!b1.out_valid) chk("r1_zero", 32'(b1.out_data), 32'h0);
      else if (b1.out_ready) begin
        e = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
        chk("r1_data", 32'(b1.out_data), 32'(e));
      end
      if (!b2.out_valid) chk("r2_zero", 32'(b2.out_data), 32'h0);
      else if (b2.out_ready) begin
        e = (q2.size() != 0) ? q2.pop_front() : 8'hxx;
        chk("r2_data", 32'(b2.out_data), 32'(e));
      end
      tick;
    end
    chk("r0_left", 32'(q0.size()), 32'h0);
    chk("r1_left", 32'(q1.size()), 32'h0);
    chk("r2_left", 32'(q2.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter DATA_W, default 8: width in bits of each channel and of the output word.
REQ-002 Parameter SEL_W, default 4: select width; the channel count N = 2^SEL_W, and SEL_W >= 1 shall hold.
REQ-003 Parameter STAGE_LVLS, default 2: mux-tree levels per register stage; STAGE_LVLS >= 1 shall hold.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_data, input, N*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port in_sel, input, SEL_W bits: selected channel index.
REQ-008 Port in_valid, input, 1 bit: in_data and in_sel are valid this cycle.
REQ-009 Port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-010 Port out_data, output, DATA_W bits: the selected channel word.
REQ-011 Port out_valid, output, 1 bit: out_data holds a result.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts out_data this cycle.

Function
REQ-013 Ordering: out_data shall equal channel in_sel of the accepted transfer, with natural binary indexing (sel=0 selects bits [DATA_W-1:0]).
REQ-014 Tree: binary 2:1 levels, with level j resolved by sel bit j (LSB first); unused sel bits are carried alongside the data through each register stage.
REQ-015 Latency: L = ceil(SEL_W/STAGE_LVLS) register stages; the last stage drives out_data and out_valid directly, with no combinational path from in_data to out_data.
REQ-016 Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-017 Stall: global advance enable en = ~out_valid | out_ready; in_ready = en.
REQ-018 Advance: when en=1, every stage loads its predecessor, and stage 0 loads the partially muxed input with valid = in_valid.
REQ-019 Hold: when en=0, all stage data and valid bits hold, and out_data stays stable while out_valid=1 and out_ready=0.
REQ-020 Throughput: with out_ready held at 1, one transfer per cycle; the first result appears L cycles after acceptance.
REQ-021 Bubbles: invalid slots propagate as bubbles; they are never presented with out_valid=1.
REQ-022 Order: results leave in acceptance order with no loss or duplication under any out_ready pattern.
REQ-023 Stage data: data registers of invalid stages are don't-care internally, but out_data shall be all-zero whenever out_valid=0.

Reset
REQ-024 On a cycle with rst=1, all stage valid bits shall clear to 0 and out_data shall clear to 0 at the next edge.
REQ-025 During rst=1, in_ready shall be 1; inputs presented during reset shall be discarded.
REQ-026 Reset mid-operation shall drop all in-flight transfers; out_valid shall be 0 in the first cycle after reset deasserts.

Configuration
REQ-027 Macro MUX_PIPE_PARITY_EN: when defined, output port out_parity (1 bit) shall equal the XOR-reduction of out_data, with the same timing as out_data, and shall reset to 0.
REQ-028 Without MUX_PIPE_PARITY_EN, the out_parity port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-029 DATA_W=8, SEL_W=4, STAGE_LVLS=2, out_ready=1; channel k = 8'h10+k; sel sweeps 0..15 back-to-back -> after 2 cycles, out_data = 8'h10..8'h1F on consecutive cycles with out_valid continuously 1.
REQ-030 Same configuration; accept sel=5 then sel=9; hold out_ready=0 for 4 cycles -> out_data holds 8'h15, in_ready=0, and after release 8'h19 follows, with no loss.
REQ-031 in_valid alternating 1/0 with sel=3 -> out_valid alternates and is never asserted on bubble slots; out_data = 0 on invalid cycles.
REQ-032 rst=1 asserted for 1 cycle while 2 transfers are in flight -> out_valid=0 and out_data=0 the next cycle; the next accepted sel=0 emerges after 2 cycles.
REQ-033 Corner configurations SEL_W=1, STAGE_LVLS=1 (L=1) and SEL_W=5, STAGE_LVLS=2 (L=3) under random valid/ready -> output matches a reference queue model.
REQ-034 With MUX_PIPE_PARITY_EN defined, channel word 8'hB3 selected -> out_parity=1; word 8'h33 -> out_parity=0.
